// File: rtl/writeback_queue_if.sv
// ============================================================================
// writeback_queue_if : enqueue, register-file write and bypass lookup signals
// Revision: 1.0
// ============================================================================
`default_nettype none

interface writeback_queue_if #(
  parameter int WordLen   = 32,
  parameter int WordCount = 32,
  parameter int Depth     = 4
);
  localparam int AW = $clog2(WordCount);
  localparam int CW = $clog2(Depth) + 1;

  logic               enqValid;
  logic               enqReady;
  logic [AW-1:0]      enqRegister;
  logic [WordLen-1:0] enqData;
  logic               drainEn;
  logic               regWrite;
  logic [AW-1:0]      writeRegister;
  logic [WordLen-1:0] writeData;
  logic [AW-1:0]      lookupRegister1;
  logic [AW-1:0]      lookupRegister2;
  logic               hit1;
  logic               hit2;
  logic [WordLen-1:0] hitData1;
  logic [WordLen-1:0] hitData2;
  logic [CW-1:0]      pendingCount;
  logic               empty;

  modport slave (
    input  enqValid, enqRegister, enqData, drainEn, lookupRegister1, lookupRegister2,
    output enqReady, regWrite, writeRegister, writeData, hit1, hit2, hitData1, hitData2,
           pendingCount, empty
  );

  modport master (
    output enqValid, enqRegister, enqData, drainEn, lookupRegister1, lookupRegister2,
    input  enqReady, regWrite, writeRegister, writeData, hit1, hit2, hitData1, hitData2,
           pendingCount, empty
  );
endinterface

`default_nettype wire

// File: rtl/writeback_queue.sv
// ============================================================================
// writeback_queue : buffers retiring results, drains them oldest-first into
//                   the register file and bypasses pending values to readers
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_queue #(
  parameter int WordLen   = 32,
  parameter int WordCount = 32,
  parameter int Depth     = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus
);
  localparam int AW = $clog2(WordCount);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [AW-1:0]      reg_q  [Depth];
  logic [AW-1:0]      reg_d  [Depth];
  logic [WordLen-1:0] data_q [Depth];
  logic [WordLen-1:0] data_d [Depth];
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic full;
  logic is_empty;
  logic push;
  logic pop;

  logic [AW-1:0]      lookup_key  [2];
  logic               lookup_hit  [2];
  logic [WordLen-1:0] lookup_data [2];

  always_comb begin
    full     = (count_q == CW'(Depth));
    is_empty = (count_q == '0);
    pop      = ~is_empty & bus.drainEn;
    // Writes to r0 complete the handshake but are dropped: r0 is hardwired zero.
    push     = bus.enqValid & ~full & (bus.enqRegister != '0);

    reg_d   = reg_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);

    if (push) begin
      reg_d[tail_q]  = bus.enqRegister;
      data_d[tail_q] = bus.enqData;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.enqReady      = ~full;
    bus.regWrite      = pop;
    bus.writeRegister = is_empty ? '0 : reg_q[head_q];
    bus.writeData     = is_empty ? '0 : data_q[head_q];
    bus.pendingCount  = count_q;
    bus.empty         = is_empty;
  end

  assign lookup_key[0] = bus.lookupRegister1;
  assign lookup_key[1] = bus.lookupRegister2;

  // Walk entries oldest to youngest from head so the last match wins,
  // independent of where the pointers currently wrap.
  for (genvar p = 0; p < 2; p++) begin : g_lookup
    always_comb begin
      lookup_hit[p]  = 1'b0;
      lookup_data[p] = '0;
      for (int k = 0; k < Depth; k++) begin
        if ((CW'(k) < count_q) && (lookup_key[p] != '0) &&
            (reg_q[head_q + PW'(k)] == lookup_key[p])) begin
          lookup_hit[p]  = 1'b1;
          lookup_data[p] = data_q[head_q + PW'(k)];
        end
      end
    end
  end

  assign bus.hit1     = lookup_hit[0];
  assign bus.hit2     = lookup_hit[1];
  assign bus.hitData1 = lookup_data[0];
  assign bus.hitData2 = lookup_data[1];

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ============================================================================
// tb_writeback_queue : directed vector table plus randomized queue-model check
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_queue;
  localparam int WL = 32;
  localparam int WC = 32;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  writeback_queue_if #(.WordLen(WL), .WordCount(WC), .Depth(DP)) bus ();

  writeback_queue #(.WordLen(WL), .WordCount(WC), .Depth(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [4:0]  er;
    logic [31:0] ed;
    logic        de;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic        rdy;
    logic [2:0]  cnt;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        h1;
    logic [31:0] hd1;
    logic        h2;
    logic [31:0] hd2;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  vec_t vecs[21];

  function automatic vec_t mk(input logic [31:0] ev, er, ed, de, l1, l2,
                              rdy, cnt, rw, wr, wd, h1, hd1, h2, hd2);
    vec_t v;
    v.ev = ev[0];  v.er = er[4:0];  v.ed = ed;  v.de = de[0];
    v.l1 = l1[4:0]; v.l2 = l2[4:0];
    v.rdy = rdy[0]; v.cnt = cnt[2:0]; v.rw = rw[0]; v.wr = wr[4:0]; v.wd = wd;
    v.h1 = h1[0]; v.hd1 = hd1; v.h2 = h2[0]; v.hd2 = hd2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input string pfx);
    chk({pfx, ".enqReady"},      32'(bus.enqReady),      32'(e.rdy));
    chk({pfx, ".pendingCount"},  32'(bus.pendingCount),  32'(e.cnt));
    chk({pfx, ".empty"},         32'(bus.empty),         32'(e.cnt == 3'd0));
    chk({pfx, ".regWrite"},      32'(bus.regWrite),      32'(e.rw));
    chk({pfx, ".writeRegister"}, 32'(bus.writeRegister), 32'(e.wr));
    chk({pfx, ".writeData"},     bus.writeData,          e.wd);
    chk({pfx, ".hit1"},          32'(bus.hit1),          32'(e.h1));
    chk({pfx, ".hitData1"},      bus.hitData1,           e.hd1);
    chk({pfx, ".hit2"},          32'(bus.hit2),          32'(e.h2));
    chk({pfx, ".hitData2"},      bus.hitData2,           e.hd2);
  endtask

  task automatic drive(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                       input logic de, input logic [4:0] l1, input logic [4:0] l2);
    @(negedge clk);
    bus.enqValid        = ev;
    bus.enqRegister     = er;
    bus.enqData         = ed;
    bus.drainEn         = de;
    bus.lookupRegister1 = l1;
    bus.lookupRegister2 = l2;
    #2;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.ev, v.er, v.ed, v.de, v.l1, v.l2);
    check_out(v, $sformatf("vec%0d", idx));
    @(posedge clk);
  endtask

  // Expected outputs straight from the queue contents.
  function automatic vec_t model_exp(input logic de, input logic [4:0] l1, input logic [4:0] l2);
    vec_t e;
    e = mk(0, 0, 0, de, l1, l2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e.rdy = (mq.size() != DP);
    e.cnt = 3'(mq.size());
    e.rw  = (mq.size() != 0) && de;
    if (mq.size() != 0) begin
      e.wr = mq[0].r;
      e.wd = mq[0].d;
    end
    for (int k = mq.size() - 1; k >= 0; k--) begin
      if (!e.h1 && l1 != 0 && mq[k].r == l1) begin e.h1 = 1'b1; e.hd1 = mq[k].d; end
      if (!e.h2 && l2 != 0 && mq[k].r == l2) begin e.h2 = 1'b1; e.hd2 = mq[k].d; end
    end
    return e;
  endfunction

  task automatic run_model(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                           input logic de, input logic [4:0] l1, input logic [4:0] l2,
                           input string pfx, output logic hs);
    logic acc;
    logic dr;
    ent_t n;
    drive(ev, er, ed, de, l1, l2);
    check_out(model_exp(de, l1, l2), pfx);
    hs  = ev && (mq.size() != DP);
    acc = hs && (er != 5'd0);
    dr  = (mq.size() != 0) && de;
    n.r = er;
    n.d = ed;
    @(posedge clk);
    if (dr)  void'(mq.pop_front());
    if (acc) mq.push_back(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.enqValid = 1'b0;
    bus.drainEn  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic hs;
    int   sent;
    int   cyc;

    bus.enqValid = 1'b0;  bus.enqRegister = '0;  bus.enqData = '0;
    bus.drainEn  = 1'b1;  bus.lookupRegister1 = '0;  bus.lookupRegister2 = '0;

    repeat (2) @(posedge clk);
    #1;
    check_out(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "in_reset");
    @(negedge clk);
    rst = 1'b0;

    //          ev er ed            de l1 l2  rdy cnt rw wr wd             h1 hd1            h2 hd2
    vecs[0]  = mk(0, 0, 0,            1, 0, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[1]  = mk(1, 5, 32'h11111111, 1, 5, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[2]  = mk(0, 0, 0,            1, 5, 0,  1, 1, 1, 5, 32'h11111111,  1, 32'h11111111,  0, 0);
    vecs[3]  = mk(0, 0, 0,            1, 5, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[4]  = mk(1, 1, 32'hA1,       0, 0, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[5]  = mk(1, 2, 32'hA2,       0, 1, 0,  1, 1, 0, 1, 32'hA1,        1, 32'hA1,        0, 0);
    vecs[6]  = mk(1, 3, 32'hA3,       0, 0, 0,  1, 2, 0, 1, 32'hA1,        0, 0,             0, 0);
    vecs[7]  = mk(1, 4, 32'hA4,       0, 0, 4,  1, 3, 0, 1, 32'hA1,        0, 0,             0, 0);
    vecs[8]  = mk(1, 6, 32'hA6,       0, 0, 4,  0, 4, 0, 1, 32'hA1,        0, 0,             1, 32'hA4);
    vecs[9]  = mk(1, 6, 32'hA6,       1, 0, 0,  0, 4, 1, 1, 32'hA1,        0, 0,             0, 0);
    vecs[10] = mk(0, 0, 0,            1, 0, 0,  1, 3, 1, 2, 32'hA2,        0, 0,             0, 0);
    vecs[11] = mk(0, 0, 0,            1, 0, 0,  1, 2, 1, 3, 32'hA3,        0, 0,             0, 0);
    vecs[12] = mk(0, 0, 0,            1, 6, 0,  1, 1, 1, 4, 32'hA4,        0, 0,             0, 0);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[14] = mk(1, 7, 32'h10,       0, 7, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[15] = mk(1, 7, 32'h20,       0, 7, 0,  1, 1, 0, 7, 32'h10,        1, 32'h10,        0, 0);
    vecs[16] = mk(0, 0, 0,            1, 7, 0,  1, 2, 1, 7, 32'h10,        1, 32'h20,        0, 0);
    vecs[17] = mk(0, 0, 0,            1, 7, 0,  1, 1, 1, 7, 32'h20,        1, 32'h20,        0, 0);
    vecs[18] = mk(0, 0, 0,            0, 7, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[19] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);
    vecs[20] = mk(0, 0, 0,            1, 0, 0,  1, 0, 0, 0, 0,             0, 0,             0, 0);

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // Wrap-around: 10 entries over registers 8..10, drain every other cycle.
    do_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 10 && cyc < 60) begin
      run_model(1'b1, 5'(8 + sent % 3), 32'h100 + 32'(sent), cyc[0], 5'd8, 5'd9, "wrap", hs);
      if (hs) sent++;
      cyc++;
    end
    chk("wrap_sent", 32'(sent), 32'd10);
    for (int i = 0; i < 6; i++) run_model(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd8, "wrap_drain", hs);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      run_model(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), "rand", hs);
    end

    // Asynchronous reset with three entries pending.
    do_reset();
    run_model(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, "pre_rst", hs);
    run_model(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0, "pre_rst", hs);
    run_model(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 5'd0, "pre_rst", hs);
    @(negedge clk);
    bus.enqValid = 1'b0;
    bus.drainEn  = 1'b1;
    bus.lookupRegister1 = 5'd3;
    bus.lookupRegister2 = 5'd5;
    #1;
    chk("pre_rst.regWrite", 32'(bus.regWrite), 32'd1);
    chk("pre_rst.hit2",     32'(bus.hit2),     32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_out(mk(0, 0, 0, 1, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0), "async_rst");
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    for (int i = 0; i < 3; i++) run_model(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd5, "post_rst", hs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
